// File: rtl/device_pkg.sv
`default_nettype none
// device_pkg: register offsets, STATUS bit positions and the serial FSM state encoding
// shared by the UART transmitter and receiver.
package device_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_TXDATA  = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  localparam int STAT_TX_FULL      = 0;
  localparam int STAT_RX_VALID     = 1;
  localparam int STAT_RX_OVERRUN   = 2;
  localparam int STAT_TX_IDLE      = 3;
  localparam int STAT_TX_OVERFLOW  = 4;
  localparam int STAT_RX_FRAME_ERR = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// sync_fifo: single-clock first-word-fall-through FIFO; pushes while full are dropped.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the current count, so a same-cycle pop cannot make room for a push.
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/device_uart.sv
`default_nettype none
// device_uart: memory-mapped 8N1 UART responder on the cluster device bus with a buffered
// transmitter, a single-entry receiver and sticky error flags.
module device_uart #(
  parameter logic [9:0]  BASE_ADDR      = 10'h000,
  parameter logic [15:0] CLOCKS_PER_BIT = 16'd434,
  parameter int          TX_FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        device_write_en,
  input  logic        device_read_en,
  input  logic [9:0]  device_addr,
  input  logic [15:0] device_data_out,
  output logic [15:0] device_data_in,
  output logic        uart_tx,
  input  logic        uart_rx
);

  import device_pkg::*;

  logic        hit, wr_acc, rd_acc;
  logic [1:0]  offset;
  logic        rd_status, rd_rxdata, wr_txdata, wr_divisor;
  logic [15:0] divisor, status_word, read_mux;
  logic        tx_overflow, rx_overrun, rx_frame_err, rx_valid;
  logic [7:0]  rx_data;

  logic        fifo_full, fifo_empty, tx_pop;
  logic [7:0]  fifo_data;

  uart_state_t tx_state;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_last;

  uart_state_t rx_state;
  logic        rx_sync1, rx_sync2, rx_prev, rx_fall;
  logic [15:0] rx_div, rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_stop_sample, rx_done_good, rx_done_bad, rx_load, rx_overrun_set;

  // A write beats a read in the same cycle; the read then returns 0.
  assign hit        = (device_addr[9:2] == BASE_ADDR[9:2]);
  assign offset     = device_addr[1:0];
  assign wr_acc     = device_write_en && hit;
  assign rd_acc     = device_read_en && !device_write_en && hit;
  assign rd_status  = rd_acc && (offset == REG_STATUS);
  assign rd_rxdata  = rd_acc && (offset == REG_RXDATA);
  assign wr_txdata  = wr_acc && (offset == REG_TXDATA);
  assign wr_divisor = wr_acc && (offset == REG_DIVISOR);

  always_comb begin
    status_word                    = '0;
    status_word[STAT_TX_FULL]      = fifo_full;
    status_word[STAT_RX_VALID]     = rx_valid;
    status_word[STAT_RX_OVERRUN]   = rx_overrun;
    status_word[STAT_TX_IDLE]      = fifo_empty && (tx_state == IDLE);
    status_word[STAT_TX_OVERFLOW]  = tx_overflow;
    status_word[STAT_RX_FRAME_ERR] = rx_frame_err;
  end

  always_comb begin
    read_mux = '0;
    case (offset)
      REG_STATUS:  read_mux = status_word;
      REG_RXDATA:  read_mux = {8'h00, rx_data};
      REG_DIVISOR: read_mux = divisor;
      default:     read_mux = '0;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_txdata),
    .push_data (device_data_out[7:0]),
    .pop       (tx_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_last = (tx_cnt == tx_div - 16'd1);
  assign tx_pop  = !fifo_empty && ((tx_state == IDLE) || ((tx_state == STOP) && tx_last));

  // A completing byte may be taken in the same cycle RXDATA is read: the read sees the old byte.
  assign rx_fall        = rx_prev && !rx_sync2;
  assign rx_stop_sample = (rx_state == STOP) && (rx_cnt == rx_div);
  assign rx_done_good   = rx_stop_sample && rx_sync2;
  assign rx_done_bad    = rx_stop_sample && !rx_sync2;
  assign rx_load        = rx_done_good && (!rx_valid || rd_rxdata);
  assign rx_overrun_set = rx_done_good && rx_valid && !rd_rxdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      device_data_in <= '0;
      divisor        <= CLOCKS_PER_BIT;
      tx_overflow    <= 1'b0;
      rx_overrun     <= 1'b0;
      rx_frame_err   <= 1'b0;
      rx_valid       <= 1'b0;
      rx_data        <= '0;
    end else begin
      device_data_in <= rd_acc ? read_mux : '0;
      if (wr_divisor) divisor <= (device_data_out < 16'd2) ? 16'd2 : device_data_out;
      tx_overflow  <= (wr_txdata && fifo_full) || (tx_overflow && !rd_status);
      rx_overrun   <= rx_overrun_set || (rx_overrun && !rd_status);
      rx_frame_err <= rx_done_bad || (rx_frame_err && !rd_status);
      rx_valid     <= rx_load || (rx_valid && !rd_rxdata);
      if (rx_load) rx_data <= rx_shift;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= IDLE;
      tx_div   <= CLOCKS_PER_BIT;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_pop) begin
            tx_shift <= fifo_data;
            tx_div   <= divisor;
            tx_cnt   <= '0;
            uart_tx  <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        STOP: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= fifo_data;
              tx_div   <= divisor;
              uart_tx  <= 1'b0;
              tx_state <= START;
            end else begin
              tx_state <= IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // rx_cnt restarts at 1 so a compare against rx_div marks exactly one bit time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_div   <= CLOCKS_PER_BIT;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync1 <= uart_rx;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      case (rx_state)
        IDLE: begin
          if (rx_fall) begin
            rx_div   <= divisor;
            rx_cnt   <= 16'd1;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == {1'b0, rx_div[15:1]}) begin
            rx_cnt <= 16'd1;
            rx_bit <= '0;
            rx_state <= rx_sync2 ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        DATA: begin
          if (rx_cnt == rx_div) begin
            rx_cnt   <= 16'd1;
            rx_shift <= {rx_sync2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        STOP: begin
          if (rx_cnt == rx_div) rx_state <= IDLE;
          else                  rx_cnt   <= rx_cnt + 16'd1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
